// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration signals: requests and freeze control from the bus
// controllers, grant/ownership/watchdog status back from the arbiter.
interface bus_arbiter_if #(
  parameter int N_REQ = 6
);
  logic [N_REQ-1:0] BR;
  logic             ARB_EN;
  logic [N_REQ-1:0] BG;
  logic [2:0]       OWNER;
  logic             OWNER_VALID;
  logic             TIMEOUT;
  logic [2:0]       TO_ID;

  modport master (
    output BR, ARB_EN,
    input  BG, OWNER, OWNER_VALID, TIMEOUT, TO_ID
  );

  modport slave (
    input  BR, ARB_EN,
    output BG, OWNER, OWNER_VALID, TIMEOUT, TO_ID
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: one-hot registered grant held until release,
// one dead turnaround cycle between tenures, tenure watchdog with revoke.
module bus_arbiter #(
  parameter int N_REQ    = 6,
  parameter int MAX_HOLD = 64,
  parameter int HOLD_W   = 8
) (
  input logic         BUS_CLK,
  input logic         RST,
  bus_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_TURN = 2'd2;

  localparam logic [2:0]        LAST_RST  = 3'(N_REQ - 1);
  localparam bit                WDOG_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = WDOG_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

  logic [1:0]        state_reg, state_next;
  logic [N_REQ-1:0]  bg_reg, bg_next;
  logic [2:0]        owner_reg, owner_next;
  logic              valid_reg, valid_next;
  logic              timeout_reg, timeout_next;
  logic [2:0]        to_id_reg, to_id_next;
  logic [2:0]        last_reg, last_next;
  logic [HOLD_W-1:0] cnt_reg, cnt_next;

  // Candidate gi is the requester at offset gi+1 after the last grantee.
  logic [2:0]       cand_id [N_REQ];
  logic [N_REQ-1:0] cand_hit;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [3:0] sum;
      assign sum          = {1'b0, last_reg} + 4'(gi + 1);
      assign cand_id[gi]  = (sum >= 4'(N_REQ)) ? 3'(sum - 4'(N_REQ)) : sum[2:0];
      assign cand_hit[gi] = bus.BR[cand_id[gi]];
    end
  endgenerate

  logic [2:0] win_id;
  always_comb begin
    win_id = cand_id[0];
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) win_id = cand_id[i];
    end
  end

  logic grant_ok;
  logic owner_req;
  assign grant_ok  = bus.ARB_EN && (|bus.BR);
  assign owner_req = bus.BR[owner_reg];

  always_comb begin
    state_next   = state_reg;
    bg_next      = bg_reg;
    owner_next   = owner_reg;
    valid_next   = valid_reg;
    timeout_next = 1'b0;
    to_id_next   = to_id_reg;
    last_next    = last_reg;
    cnt_next     = cnt_reg;
    case (state_reg)
      ST_OWN: begin
        if (cnt_reg != '1) cnt_next = cnt_reg + HOLD_W'(1);
        // A release on the expiry edge takes precedence over the revoke.
        if (!owner_req) begin
          bg_next    = '0;
          valid_next = 1'b0;
          state_next = ST_TURN;
        end else if (WDOG_EN && (cnt_reg == HOLD_LAST)) begin
          bg_next      = '0;
          valid_next   = 1'b0;
          timeout_next = 1'b1;
          to_id_next   = owner_reg;
          state_next   = ST_TURN;
        end
      end
      default: begin
        if (grant_ok) begin
          bg_next    = N_REQ'(1) << win_id;
          owner_next = win_id;
          valid_next = 1'b1;
          last_next  = win_id;
          cnt_next   = '0;
          state_next = ST_OWN;
        end else begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= ST_IDLE;
      bg_reg      <= '0;
      owner_reg   <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      to_id_reg   <= '0;
      last_reg    <= LAST_RST;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      bg_reg      <= bg_next;
      owner_reg   <= owner_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
      to_id_reg   <= to_id_next;
      last_reg    <= last_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign bus.BG          = bg_reg;
  assign bus.OWNER       = owner_reg;
  assign bus.OWNER_VALID = valid_reg;
  assign bus.TIMEOUT     = timeout_reg;
  assign bus.TO_ID       = to_id_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks of bus_arbiter against a tenure-level
// reference model (owner, cycles owned, round-robin pointer).
module tb_bus_arbiter;
  localparam int N    = 6;
  localparam int MAXH = 4;

  logic BUS_CLK = 1'b0;
  logic RST     = 1'b1;
  always #5 BUS_CLK = ~BUS_CLK;

  bus_arbiter_if #(.N_REQ(N)) bus ();

  bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH), .HOLD_W(8)) dut (
    .BUS_CLK (BUS_CLK),
    .RST     (RST),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the bus (-1 none), how many cycles it has owned.
  int m_owner, m_owner_id, m_last, m_ten, m_to_id;
  bit m_to;

  int exp_ord [7] = '{0, 1, 2, 3, 4, 5, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_owner_id = 0;
    m_last     = N - 1;
    m_ten      = 0;
    m_to       = 1'b0;
    m_to_id    = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] br, input logic en);
    int id;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      m_ten++;
      if (!br[m_owner]) begin
        m_owner = -1;
      end else if (MAXH != 0 && m_ten == MAXH) begin
        m_to    = 1'b1;
        m_to_id = m_owner;
        m_owner = -1;
      end
    end else if (en && br != '0) begin
      for (int k = 1; k <= N; k++) begin
        id = (m_last + k) % N;
        if (br[id]) begin
          m_owner    = id;
          m_owner_id = id;
          m_last     = id;
          m_ten      = 0;
          break;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e_bg;
    e_bg = (m_owner >= 0) ? N'(1) << m_owner : '0;
    chk("BG", bus.BG, e_bg);
    chk("OWNER", bus.OWNER, m_owner_id);
    chk("OWNER_VALID", bus.OWNER_VALID, (m_owner >= 0));
    chk("TIMEOUT", bus.TIMEOUT, m_to);
    chk("TO_ID", bus.TO_ID, m_to_id);
    chk("BG_onehot0", $onehot0(bus.BG), 1);
  endtask

  task automatic step();
    logic [N-1:0] br_s;
    logic         en_s;
    br_s = bus.BR;
    en_s = bus.ARB_EN;
    @(posedge BUS_CLK);
    if (RST) model_edge(br_s, en_s);
    #1;
    check_all();
  endtask

  // Called 1 time unit after a rising edge; asserts reset between edges.
  task automatic do_reset();
    #2 RST = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_valid", bus.OWNER_VALID, 0);
    @(posedge BUS_CLK);
    #1;
    check_all();
    RST = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    bus.BR     = '0;
    bus.ARB_EN = 1'b0;
    model_reset();
    #1 RST = 1'b0;
    #1;
    check_all();
    chk("rst_BG", bus.BG, 0);
    @(posedge BUS_CLK);
    #1;
    RST        = 1'b1;
    bus.ARB_EN = 1'b1;

    // Single requester grant and release
    bus.BR = 6'b000001; step();
    chk("t1_grant", bus.BG, 6'b000001);
    chk("t1_owner", bus.OWNER, 0);
    bus.BR = '0; step();
    chk("t1_gap", bus.BG, 0);
    step();
    chk("t1_idle", bus.BG, 0);

    // Full rotation with all requesting
    do_reset();
    bus.BR = 6'h3F; step();
    for (int i = 0; i < 7; i++) begin
      chk("t2_order", bus.OWNER, exp_ord[i]);
      chk("t2_valid", bus.OWNER_VALID, 1);
      step(); step();
      bus.BR = 6'h3F & ~(6'(1) << exp_ord[i]);
      step();
      chk("t2_gap", bus.BG, 0);
      bus.BR = 6'h3F;
      step();
    end
    bus.BR = '0; step(); step();

    // Wrap-around from owner 3
    bus.BR = 6'b001000; step();
    chk("t3_own3", bus.OWNER, 3);
    step();
    bus.BR = 6'b100101; step();
    chk("t3_rel", bus.BG, 0);
    step();
    chk("t3_g5", bus.BG, 6'b100000);
    bus.BR = 6'b000101; step(); step();
    chk("t3_g0", bus.BG, 6'b000001);
    bus.BR = 6'b000100; step(); step();
    chk("t3_g2", bus.BG, 6'b000100);
    bus.BR = '0; step(); step();

    // Watchdog revoke and re-grant
    bus.BR = 6'b000100; step();
    chk("t4_grant", bus.BG, 6'b000100);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold", bus.BG, 6'b000100);
    end
    step();
    chk("t4_drop", bus.BG, 0);
    chk("t4_timeout", bus.TIMEOUT, 1);
    chk("t4_to_id", bus.TO_ID, 2);
    step();
    chk("t4_regrant", bus.BG, 6'b000100);
    chk("t4_to_clear", bus.TIMEOUT, 0);
    bus.BR = 6'b010100;
    for (int i = 0; i < 3; i++) step();
    step();
    chk("t4_drop2", bus.BG, 0);
    step();
    chk("t4_g4", bus.BG, 6'b010000);
    bus.BR = 6'b000100; step(); step();
    chk("t4_g2", bus.BG, 6'b000100);
    bus.BR = '0; step(); step();

    // Arbitration freeze
    bus.ARB_EN = 1'b0;
    bus.BR     = 6'b000011;
    repeat (3) begin
      step();
      chk("t5_frozen", bus.BG, 0);
    end
    bus.ARB_EN = 1'b1; step();
    chk("t5_g0", bus.BG, 6'b000001);
    bus.ARB_EN = 1'b0; step(); step();
    chk("t5_keep", bus.BG, 6'b000001);
    bus.BR = 6'b000010; step();
    chk("t5_rel", bus.BG, 0);
    step(); step();
    chk("t5_nogrant", bus.BG, 0);

    // Asynchronous reset mid-tenure
    bus.ARB_EN = 1'b1; step();
    chk("t6_g1", bus.BG, 6'b000010);
    step();
    #2 RST = 1'b0;
    #1;
    chk("t6_rst_bg", bus.BG, 0);
    chk("t6_rst_valid", bus.OWNER_VALID, 0);
    chk("t6_rst_timeout", bus.TIMEOUT, 0);
    chk("t6_rst_to_id", bus.TO_ID, 0);
    model_reset();
    check_all();
    @(posedge BUS_CLK);
    #1;
    bus.BR = 6'b100000;
    RST    = 1'b1;
    step();
    chk("t6_g5", bus.BG, 6'b100000);
    do_reset();
    bus.BR = 6'b100001; step();
    chk("t6_g0", bus.BG, 6'b000001);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      r = bus.BR;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      bus.BR     = r;
      bus.ARB_EN = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the shared system bus (D, A, MASTER, DEST, SIZE, RW, ACK). It collects bus requests from the six bus controllers (`BR`) and issues at most one one-hot grant (`BG`). It holds that grant until the owner releases its request, then inserts one dead cycle so tristate drivers can turn around. A tenure watchdog revokes a grant from a master that holds the bus too long. The block sits beside the bus controllers on `BUS_CLK`.

## Interface
- `N_REQ`, 6, number of requesters; `BR`/`BG` width; IDs 0..N_REQ-1 encoded in 3 bits.
- `MAX_HOLD`, 64, maximum owned cycles before forced revoke; 0 disables the watchdog.
- `HOLD_W`, 8, tenure counter width; must satisfy MAX_HOLD < 2^HOLD_W.

Ports:
- `BUS_CLK` in 1: bus clock; all state on its rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `BR` in N_REQ: bus request, one bit per controller; held high for the whole transaction.
- `ARB_EN` in 1: high allows new grants; low freezes arbitration, but the current owner keeps the bus.
- `BG` out N_REQ: bus grant, one-hot or zero, registered.
- `OWNER` out 3: encoded ID of the current grantee; equals the `MASTER` value the grantee drives.
- `OWNER_VALID` out 1: high when `BG` is nonzero.
- `TIMEOUT` out 1: one-cycle pulse on a watchdog revoke.
- `TO_ID` out 3: ID of the last revoked master; holds until the next revoke.

## Operation
- States: IDLE, OWN, TURN.
- Reset values:
  - State = IDLE.
  - `BG`=0, `OWNER`=0, `OWNER_VALID`=0, `TIMEOUT`=0, `TO_ID`=0.
  - Round-robin pointer `LAST`=N_REQ-1, so requester 0 has first priority.
  - Tenure counter = 0.
- Selection: search `BR` starting at (`LAST`+1) mod N_REQ and wrapping to `LAST`; the first set bit wins. The winner becomes `LAST` when granted.
- IDLE:
  - If `ARB_EN`=1 and `BR`≠0: grant the winner (set `BG[w]`, `OWNER`=w, `OWNER_VALID`=1), clear the counter, go to OWN.
  - Otherwise stay in IDLE.
- OWN:
  - Counter increments each cycle, saturating at 2^HOLD_W-1.
  - If `BR[OWNER]`=0: release. Clear `BG`, clear `OWNER_VALID`, go to TURN. `OWNER` keeps its last value.
  - Else, if MAX_HOLD≠0 and counter = MAX_HOLD-1: revoke. Clear `BG`, pulse `TIMEOUT`, set `TO_ID`=`OWNER`, go to TURN.
  - Else stay in OWN. Changes on other `BR` bits are ignored.
  - `ARB_EN` has no effect in OWN.
- TURN: exactly one cycle with no grant. Then the same decision as IDLE: grant directly if `ARB_EN`=1 and `BR`≠0, else go to IDLE.
- A revoked master whose `BR` is still high competes normally. Because `LAST` equals its ID, it has the lowest priority. If it is the only requester it is re-granted after TURN.
- A requester that drops `BR` before being granted loses nothing; it is not remembered.
- Invariant: `BG` never has more than one bit set, and `BG` is never nonzero in TURN.

## Timing
- Grant latency: `BR` high before edge k while in IDLE → `BG` high after edge k (1 cycle).
- Release: `BR[owner]` sampled low at edge m → `BG`=0 after m (TURN) → next grant after edge m+1 at the earliest. The inter-tenure gap is exactly one cycle.
- Minimum tenure: 1 cycle. If `BR` drops in the first OWN cycle, `BG` is high for one cycle.
- Watchdog with MAX_HOLD=M: `BG` stays high for exactly M cycles, then drops. `TIMEOUT` is high in the first cycle of TURN only.
- Release and watchdog expiry on the same edge: release wins; `TIMEOUT` is not pulsed.
- `RST` low at any time, including mid-tenure: all outputs go to their reset values immediately, without waiting for a clock edge. The first grant after reset is evaluated on the first edge with `RST` high.
- All outputs are registered; there is no combinational path from `BR` to `BG`.

## Test plan
- Reset then `BR`=6'b000001 → `BG`=6'b000001 one cycle later, `OWNER`=0. Drop `BR` → one cycle `BG`=0, then `BG`=0 stays in IDLE.
- `BR`=6'b111111 held, each owner drops its bit for one cycle after 3 cycles of tenure → grant order 0,1,2,3,4,5,0, with exactly one `BG`=0 cycle between tenures.
- After owner 3 releases, `BR`=6'b100101 → next grant is 5, then 0, then 2 (wrap-around from `LAST`).
- MAX_HOLD=4, `BR`=6'b000100 held forever → `BG[2]` high for 4 cycles, `TIMEOUT` pulse, `TO_ID`=2, one gap cycle, then re-grant to 2. With `BR[4]` also high, 4 is granted before 2.
- `ARB_EN`=0 with `BR`=6'b000011 → `BG` stays 0. Set `ARB_EN`=1 → `BG`=6'b000001. Clear `ARB_EN` mid-tenure → the owner keeps `BG` until it releases, then no new grant.
- Assert `RST` low mid-tenure, between clock edges → `BG`, `OWNER_VALID`, `TIMEOUT` go to 0 at once. Release reset with `BR`=6'b100000 → grant 5 on the next edge, with `LAST` reset so 0 would have priority if requesting.
